// File: rtl/lu_recompose.sv
// lu_recompose: rebuilds A = L*U from a unit-lower L and an upper U with one
// multiply-accumulate per clock. L and U are loaded through a write port and the
// result A is read back through a registered read port.
// Optional build macro: LU_RECOMP_OVF_EN enables sticky signed-overflow detection.
module lu_recompose #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              finish,
  output logic              ovf
);

  localparam int unsigned NN    = N * N;
  localparam int unsigned MEM_D = 2 ** ADDR_W;
  localparam int          IW    = $clog2(N);
  localparam logic [IW-1:0] IMAX = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StMac, StStore, StDone} state_e;

  state_e state_q, state_d;

  // Memories are sized to the full address space so any address indexes safely.
  logic [DATA_W-1:0] l_mem [MEM_D];
  logic [DATA_W-1:0] u_mem [MEM_D];
  logic [DATA_W-1:0] a_mem [MEM_D];

  logic [IW-1:0]     i_q, j_q, k_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              busy_q, finish_q;

  logic              accept_start, mac_en, store_en, last_entry;
  logic [IW-1:0]     min_ij;
  logic [ADDR_W-1:0] l_addr, u_addr, a_addr;
  logic [DATA_W-1:0] l_val, u_val, prod, sum;
  logic              wr_ok;

  assign min_ij     = (i_q < j_q) ? i_q : j_q;
  assign last_entry = (i_q == IMAX) && (j_q == IMAX);
  assign l_addr     = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q);
  assign u_addr     = ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);
  assign a_addr     = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);
  assign l_val      = l_mem[l_addr];
  assign u_val      = u_mem[u_addr];
  assign sum        = acc_q + prod;
  assign wr_ok      = wr && !busy_q && (32'(wr_addr) < NN);

`ifdef LU_RECOMP_OVF_EN
  logic [2*DATA_W-1:0] prod_full;
  logic                prod_ovf, acc_ovf, ovf_q;

  // Sign-extended operands: the low 2*DATA_W bits equal the signed product.
  assign prod_full = {{DATA_W{l_val[DATA_W-1]}}, l_val} * {{DATA_W{u_val[DATA_W-1]}}, u_val};
  assign prod      = prod_full[DATA_W-1:0];
  assign prod_ovf  = (prod_full[2*DATA_W-1:DATA_W-1] != '0) &&
                     (prod_full[2*DATA_W-1:DATA_W-1] != '1);
  assign acc_ovf   = (acc_q[DATA_W-1] == prod[DATA_W-1]) && (sum[DATA_W-1] != acc_q[DATA_W-1]);

  // Sticky overflow flag, cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (accept_start) begin
      ovf_q <= 1'b0;
    end else if (mac_en && (prod_ovf || acc_ovf)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  // Low DATA_W bits of the product are sign-independent.
  assign prod = l_val * u_val;
  assign ovf  = 1'b0;
`endif

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    mac_en       = 1'b0;
    store_en     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StMac;
          accept_start = 1'b1;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (k_q == min_ij) state_d = StStore;
      end
      StStore: begin
        store_en = 1'b1;
        state_d  = last_entry ? StDone : StMac;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Loop indices, accumulator, status flags and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= (32'(rd_addr) < NN) ? a_mem[rd_addr] : '0;
      if (accept_start) begin
        i_q      <= '0;
        j_q      <= '0;
        k_q      <= '0;
        acc_q    <= '0;
        busy_q   <= 1'b1;
        finish_q <= 1'b0;
      end
      if (mac_en) begin
        acc_q <= sum;
        if (k_q != min_ij) k_q <= k_q + 1'b1;
      end
      if (store_en) begin
        acc_q <= '0;
        k_q   <= '0;
        if (last_entry) begin
          i_q      <= '0;
          j_q      <= '0;
          busy_q   <= 1'b0;
          finish_q <= 1'b1;
        end else if (j_q != IMAX) begin
          j_q <= j_q + 1'b1;
        end else begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end
      end
    end
  end

  // Storage writes; contents survive reset, but a reset edge blocks the result store.
  always_ff @(posedge clk) begin
    if (wr_ok && !wr_sel) l_mem[wr_addr] <= wr_data;
    if (wr_ok && wr_sel)  u_mem[wr_addr] <= wr_data;
    if (store_en && !reset) a_mem[a_addr] <= acc_q;
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign finish  = finish_q;

endmodule

// File: tb/tb_lu_recompose.sv
// Directed bench for lu_recompose (N=4, 32-bit): table of L/U/A vectors plus
// hand-written busy-interlock and mid-run reset sequences.
module tb_lu_recompose;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef LU_RECOMP_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, wr, wr_sel, start;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          busy, finish, ovf;

  lu_recompose #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .wr_sel (wr_sel),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start  (start),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy),
    .finish (finish),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef logic [15:0][31:0] mat_t;
  typedef struct {
    string name;
    mat_t  l;
    mat_t  u;
    mat_t  a;
    logic  ovf;
  } vec_t;

  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input mat_t l, input mat_t u);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        @(negedge clk);
        wr      = 1'b1;
        wr_sel  = (s == 1);
        wr_addr = AW'(a);
        wr_data = (s == 0) ? l[a] : u[a];
      end
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic check_a(input string name, input mat_t a);
    for (int idx = 0; idx < 16; idx++) begin
      @(negedge clk);
      rd_addr = AW'(idx);
      @(posedge clk);
      #1;
      check($sformatf("%s A[%0d]", name, idx), rd_data, a[idx]);
    end
  endtask

  // Start a run and count rising edges (start edge = 1) until finish is seen.
  // When inject_at > 0, a start pulse and an L[0][0]=99 write are driven after that edge.
  task automatic run(input int inject_at, output int edges, output int busy_cycles);
    @(negedge clk);
    start       = 1'b1;
    busy_cycles = 0;
    @(posedge clk);
    edges = 1;
    #1;
    start = 1'b0;
    while (!finish && edges < 200) begin
      if (busy) busy_cycles++;
      if (edges == inject_at) begin
        start   = 1'b1;
        wr      = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = 32'd99;
      end
      @(posedge clk);
      edges++;
      #1;
      start = 1'b0;
      wr    = 1'b0;
    end
  endtask

  task automatic run_and_check(input string name, input int inject_at, input vec_t v);
    int e, b;
    run(inject_at, e, b);
    check({name, " finish edge"}, 32'(e), 32'd47);
    check({name, " busy cycles"}, 32'(b), 32'd46);
    check({name, " busy at finish"}, 32'(busy), 32'd0);
    check({name, " ovf"}, 32'(ovf), 32'(v.ovf));
    check_a(name, v.a);
  endtask

  initial begin
    mat_t id, l, u, a;
    reset   = 1'b1;
    wr      = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    rd_addr = '0;

    id = '0;
    for (int i = 0; i < N; i++) id[i*5] = 32'd1;

    vecs[0] = '{name: "identity", l: id, u: id, a: id, ovf: 1'b0};

    l = id; u = id; a = id;
    l[0] = 32'h0001_0000; u[0] = 32'h0001_0000; a[0] = 32'h0;
    vecs[1] = '{name: "overflow", l: l, u: u, a: a, ovf: OVF_ON};

    l = id; l[4] = 32'd2;
    u = '0; u[0] = 32'd3; u[5] = 32'd3; u[10] = 32'd3; u[15] = 32'd3; u[1] = 32'd4;
    a = '0; a[0] = 32'd3; a[1] = 32'd4; a[4] = 32'd6; a[5] = 32'd11; a[10] = 32'd3;
    a[15] = 32'd3;
    vecs[2] = '{name: "worked", l: l, u: u, a: a, ovf: 1'b0};

    l = id; l[4] = 32'hFFFF_FFFF;
    u = id; u[0] = 32'd5;
    a = id; a[0] = 32'd5; a[4] = 32'hFFFF_FFFB;
    vecs[3] = '{name: "wrap", l: l, u: u, a: a, ovf: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset finish", 32'(finish), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Overflow precedes a clean run, so the clean run also shows ovf clearing on start.
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].l, vecs[v].u);
      run_and_check(vecs[v].name, 0, vecs[v]);
    end

    // Start and write while busy must both be ignored.
    load(vecs[2].l, vecs[2].u);
    run_and_check("interlock", 5, vecs[2]);

    // Reset ten edges into a run, then recompute from scratch.
    load(vecs[1].l, vecs[1].u);
    @(negedge clk);
    rd_addr = AW'(15);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset finish", 32'(finish), 32'd0);
    check("midreset ovf", 32'(ovf), 32'd0);
    check("midreset rd_data", rd_data, 32'd0);
    reset = 1'b0;
    run_and_check("after reset", 0, vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
